// File: rtl/instr_encoder.sv
// Instruction encoder and instruction-memory loader: assembles descriptors into MIPS words
// and writes them to consecutive addresses from a programmable base.
module instr_encoder #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [3:0]        op_sel,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;
   localparam logic [1:0] StErr  = 2'd3;

   localparam logic [ADDR_W:0] Full = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        code_q, code_d;
   logic [31:0]       word;
   logic              legal;
   logic              full;

   always_comb begin
      legal = 1'b1;
      word  = '0;
      case (op_sel)
         4'd0:    word = {6'b000000, rs, rt, rd, 5'b0, 6'b100001};
         4'd1:    word = {6'b000000, rs, rt, rd, 5'b0, 6'b100011};
         4'd2:    word = {6'b001101, rs, rt, imm};
         4'd3:    word = {6'b001001, rs, rt, imm};
         4'd4:    word = {6'b100011, rs, rt, imm};
         4'd5:    word = {6'b101011, rs, rt, imm};
         4'd6:    word = {6'b000100, rs, rt, imm};
         4'd7:    word = {6'b000010, target};
         4'd8:    word = {6'b001000, rs, rt, imm};
         4'd9:    word = {6'b001111, 5'b0, rt, imm};
         default: legal = 1'b0;
      endcase
   end

   assign full     = (count_q == Full);
   assign in_ready = (state_q == StRun) && !start && !full;

   // start wins over any same-cycle descriptor; in_ready is already low then
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      code_d  = code_q;
      if (start) begin
         state_d = StRun;
         ptr_d   = base_addr;
         count_d = '0;
         code_d  = 2'b00;
      end else if (state_q == StRun && in_valid) begin
         if (full) begin
            state_d = StErr;
            code_d  = 2'b10;
         end else if (legal) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = word;
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
            if (in_last) state_d = StDone;
         end else begin
            state_d = StErr;
            code_d  = 2'b01;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         code_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         code_q  <= code_d;
      end
   end

   assign im_we    = we_q;
   assign im_addr  = addr_q;
   assign im_wdata = wdata_q;
   assign count    = count_q;
   assign done     = (state_q == StDone);
   assign err      = (state_q == StErr);
   assign err_code = code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a session-level reference model.
module tb_instr_encoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
   logic [3:0]  op_sel = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0;
   logic [15:0] imm = '0;
   logic [25:0] target = '0;
   logic [7:0]  base_a = '0;
   logic [1:0]  base_b = '0;

   logic        a_ready, a_we, a_done, a_err;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic [8:0]  a_count;
   logic [1:0]  a_code;
   logic        b_ready, b_we, b_done, b_err;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_count;
   logic [1:0]  b_code;

   instr_encoder #(.ADDR_W(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_a), .in_valid(in_valid),
      .in_ready(a_ready), .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
      .imm(imm), .target(target), .im_we(a_we), .im_addr(a_addr), .im_wdata(a_wdata),
      .count(a_count), .done(a_done), .err(a_err), .err_code(a_code)
   );

   instr_encoder #(.ADDR_W(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_b), .in_valid(in_valid),
      .in_ready(b_ready), .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
      .imm(imm), .target(target), .im_we(b_we), .im_addr(b_addr), .im_wdata(b_wdata),
      .count(b_count), .done(b_done), .err(b_err), .err_code(b_code)
   );

   // sel picks which instance the model tracks: 0 -> ADDR_W=8, 1 -> ADDR_W=2
   bit sel = 1'b0;
   logic        o_ready, o_we, o_done, o_err;
   logic [31:0] o_addr, o_wdata, o_count;
   logic [1:0]  o_code;
   assign o_ready = sel ? b_ready : a_ready;
   assign o_we    = sel ? b_we : a_we;
   assign o_done  = sel ? b_done : a_done;
   assign o_err   = sel ? b_err : a_err;
   assign o_addr  = sel ? 32'(b_addr) : 32'(a_addr);
   assign o_wdata = sel ? b_wdata : a_wdata;
   assign o_count = sel ? 32'(b_count) : 32'(a_count);
   assign o_code  = sel ? b_code : a_code;

   int checks = 0;
   int errors = 0;

   bit m_active, m_done, m_err;
   int m_ptr, m_count, m_code;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int depth();
      return sel ? 4 : 256;
   endfunction

   // Word assembled from the mnemonic table using field weights
   function automatic logic [31:0] enc(input int op, input int s, input int t, input int d,
                                       input int im, input int tg, output bit legal);
      int opc[10] = '{0, 0, 13, 9, 35, 43, 4, 2, 8, 15};
      logic [31:0] f_rs, f_rt, f_rd, f_op;
      legal = (op >= 0 && op <= 9);
      if (!legal) return 32'd0;
      f_op = 32'(opc[op]) * 32'h0400_0000;
      f_rs = 32'(s) * 32'h0020_0000;
      f_rt = 32'(t) * 32'h0001_0000;
      f_rd = 32'(d) * 32'h0000_0800;
      if (op <= 1) return f_rs + f_rt + f_rd + ((op == 0) ? 32'd33 : 32'd35);
      if (op == 7) return f_op + 32'(tg);
      if (op == 9) return f_op + f_rt + 32'(im);
      return f_op + f_rs + f_rt + 32'(im);
   endfunction

   task automatic model_reset();
      m_active = 0; m_done = 0; m_err = 0; m_ptr = 0; m_count = 0; m_code = 0;
   endtask

   // One clock: drive at negedge, check ready, predict, check registered outputs next negedge
   task automatic cycle(input bit st, input logic [7:0] b, input bit v, input bit l,
                        input int op, input int s, input int t, input int d, input int im,
                        input int tg, input logic [31:0] lit = 32'd0, input bit lit_en = 1'b0);
      bit exp_ready, exp_we, legal;
      int exp_addr;
      logic [31:0] exp_data, w;
      start = st; base_a = b; base_b = b[1:0]; in_valid = v; in_last = l;
      op_sel = op[3:0]; rs = s[4:0]; rt = t[4:0]; rd = d[4:0]; imm = im[15:0];
      target = tg[25:0];
      #1;
      exp_ready = m_active && !st && (m_count < depth());
      check("in_ready", 32'(o_ready), 32'(exp_ready));
      exp_we = 0; exp_addr = 0; exp_data = 0;
      if (st) begin
         m_active = 1; m_ptr = int'(b) % depth(); m_count = 0;
         m_done = 0; m_err = 0; m_code = 0;
      end else if (m_active && v) begin
         if (m_count >= depth()) begin
            m_active = 0; m_err = 1; m_code = 2;
         end else begin
            w = enc(op, s, t, d, im, tg, legal);
            if (legal) begin
               exp_we = 1; exp_addr = m_ptr; exp_data = w;
               m_ptr = (m_ptr + 1) % depth();
               m_count++;
               if (l) begin m_active = 0; m_done = 1; end
            end else begin
               m_active = 0; m_err = 1; m_code = 1;
            end
         end
      end
      @(negedge clk);
      check("im_we", 32'(o_we), 32'(exp_we));
      if (exp_we) begin
         check("im_addr", o_addr, 32'(exp_addr));
         check("im_wdata", o_wdata, exp_data);
      end
      if (lit_en) check("im_wdata_lit", o_wdata, lit);
      check("done", 32'(o_done), 32'(m_done));
      check("err", 32'(o_err), 32'(m_err));
      check("err_code", 32'(o_code), 32'(m_code));
      check("count", o_count, 32'(m_count));
   endtask

   task automatic idle();
      cycle(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"}, 32'(o_we), 32'd0);
      check({tag, "_addr"}, o_addr, 32'd0);
      check({tag, "_wdata"}, o_wdata, 32'd0);
      check({tag, "_ready"}, 32'(o_ready), 32'd0);
      check({tag, "_count"}, o_count, 32'd0);
      check({tag, "_done"}, 32'(o_done), 32'd0);
      check({tag, "_err"}, 32'(o_err), 32'd0);
      check({tag, "_code"}, 32'(o_code), 32'd0);
   endtask

   initial begin
      model_reset();
      #12;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Program load
      sel = 0;
      cycle(1, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0, 1, 2, 3, 0, 0, 32'h0022_1821, 1);
      cycle(0, 8'h00, 1, 0, 2, 0, 8, 0, 16'h00FF, 0, 32'h3408_00FF, 1);
      cycle(0, 8'h00, 1, 1, 4, 29, 9, 0, 4, 0, 32'h8FA9_0004, 1);
      check("load_done", 32'(o_done), 32'd1);
      check("load_count", o_count, 32'd3);
      idle();

      // Formats
      cycle(1, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 7, 0, 0, 0, 0, 26'h0000040, 32'h0800_0040, 1);
      cycle(0, 8'h00, 1, 0, 9, 7, 1, 0, 16'h1234, 0, 32'h3C01_1234, 1);
      cycle(0, 8'h00, 1, 1, 6, 1, 2, 0, 16'hFFFF, 0, 32'h1022_FFFF, 1);

      // Illegal op as second descriptor
      cycle(1, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0, 4, 5, 6, 0, 0);
      cycle(0, 8'h00, 1, 0, 12, 4, 5, 6, 0, 0);
      check("illegal_code", 32'(o_code), 32'd1);
      check("illegal_count", o_count, 32'd1);
      cycle(0, 8'h00, 1, 0, 0, 1, 1, 1, 0, 0);
      cycle(0, 8'h00, 1, 1, 3, 1, 1, 1, 0, 0);

      // Overflow and wrap on the 2-bit instance
      sel = 1;
      cycle(1, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 8'h00, 1, 0, 3, i, i + 1, 0, i * 7, 0);
         if (i < 4) check("wrap_addr", o_addr, 32'((3 + i) % 4));
      end
      check("ovf_code", 32'(o_code), 32'd2);
      idle();
      idle();

      // Start priority over a same-cycle descriptor
      sel = 0;
      cycle(1, 8'h05, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0, 1, 2, 3, 0, 0);
      cycle(1, 8'h20, 1, 0, 1, 1, 2, 3, 0, 0);
      check("prio_count", o_count, 32'd0);
      cycle(0, 8'h00, 1, 0, 2, 1, 2, 0, 16'h0F0F, 0);
      check("prio_addr", o_addr, 32'h20);

      // Randomized sessions
      for (int sess = 0; sess < 40; sess++) begin
         int n;
         sel = bit'($urandom_range(0, 1));
         cycle(1, 8'($urandom), 0, 0, 0, 0, 0, 0, 0, 0);
         n = $urandom_range(3, 24);
         for (int c = 0; c < n; c++) begin
            int op;
            op = ($urandom_range(0, 24) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            cycle($urandom_range(0, 39) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, op, $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
                  int'($urandom & 32'h03FF_FFFF));
         end
      end

      // Asynchronous reset during a back-to-back stream
      sel = 0;
      cycle(1, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0, 1, 2, 3, 0, 0);
      cycle(0, 8'h00, 1, 0, 3, 4, 5, 0, 99, 0);
      check("pre_rst_we", 32'(o_we), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 8'h00, 1, 0, 0, 1, 2, 3, 0, 0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
